// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port data memory between the CPU MEM stage and an external port.
// CPU has priority. Starved external requests are forced through. Locked bursts give the external port exclusive ownership.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 8,
  parameter int BURST_MAX  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {OWN_CPU, OWN_EXT} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_EXT} rd_owner_t;

  state_t    state_reg, state_next;
  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
  logic [BW-1:0] burst_cnt_reg, burst_cnt_next;
  logic [BW-1:0] burst_cnt_inc;
  logic      first_back_reg, first_back_next;
  rd_owner_t rd_owner_reg, rd_owner_next;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg      <= OWN_CPU;
      starve_cnt_reg <= '0;
      burst_cnt_reg  <= '0;
      first_back_reg <= 1'b0;
      rd_owner_reg   <= RD_NONE;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      burst_cnt_reg  <= burst_cnt_next;
      first_back_reg <= first_back_next;
      rd_owner_reg   <= rd_owner_next;
    end
  end

  assign burst_cnt_inc = burst_cnt_reg + BW'(1);

  // Next-state logic
  always_comb begin
    state_next      = state_reg;
    burst_cnt_next  = burst_cnt_reg;
    first_back_next = 1'b0;
    starve_cnt_next = starve_cnt_reg;

    case (state_reg)
      OWN_CPU: begin
        if (ext_gnt && ext_lock && (BURST_MAX > 1)) begin
          state_next     = OWN_EXT;
          burst_cnt_next = BW'(1);
        end
      end
      OWN_EXT: begin
        // Exit when the lock or request drops, or when this grant completes the burst.
        // The first OWN_CPU cycle after an exit belongs to the CPU.
        if (!ext_gnt || (burst_cnt_inc == BW'(BURST_MAX))) begin
          state_next      = OWN_CPU;
          burst_cnt_next  = '0;
          first_back_next = 1'b1;
        end else begin
          burst_cnt_next = burst_cnt_inc;
        end
      end
      default: begin
        state_next = OWN_CPU;
      end
    endcase

    if (!ext_req || ext_gnt) begin
      starve_cnt_next = '0;
    end else if ((state_reg == OWN_CPU) && (starve_cnt_reg < SW'(STARVE_LIM))) begin
      starve_cnt_next = starve_cnt_reg + SW'(1);
    end

    rd_owner_next = RD_NONE;
    if (cpu_gnt && !cpu_wen) begin
      rd_owner_next = RD_CPU;
    end else if (ext_gnt && !ext_wen) begin
      rd_owner_next = RD_EXT;
    end
  end

  // Output logic: grants are gated by reset so nothing reaches the SRAM while it is held
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (arst_n) begin
      case (state_reg)
        OWN_CPU: begin
          if (cpu_req && ((starve_cnt_reg < SW'(STARVE_LIM)) || !ext_req || first_back_reg)) begin
            cpu_gnt = 1'b1;
          end else if (ext_req) begin
            ext_gnt = 1'b1;
          end
        end
        OWN_EXT: begin
          ext_gnt = ext_req & ext_lock;
        end
        default: begin
          cpu_gnt = 1'b0;
        end
      endcase
    end

    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
      mem_ren   = ~cpu_wen;
    end else if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_wen;
      mem_ren   = ~ext_wen;
    end
  end

  assign stall      = cpu_req & ~cpu_gnt;
  assign cpu_rvalid = (rd_owner_reg == RD_CPU);
  assign ext_rvalid = (rd_owner_reg == RD_EXT);
  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;

endmodule
